// File: rtl/summer_pkg.sv
// Shared helpers for the pipelined signed summer: level-count math and the
// output saturate/wrap function.
package summer_pkg;

   // Widest value the output stage handles internally; SUM_W must stay below it.
   localparam int unsigned MaxW = 128;

   typedef struct packed {
      logic            sat;
      logic [MaxW-1:0] result;
   } sat_res_t;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((longint'(1) << r) < longint'(n)) begin
         r++;
      end
      return r;
   endfunction

   // Tree depth: N_IN operands plus the bias leaf.
   function automatic int unsigned num_levels(input int unsigned n_in);
      return clog2(n_in + 1);
   endfunction

   function automatic sat_res_t sat_trunc(input logic signed [MaxW-1:0] value,
                                          input int unsigned out_w,
                                          input int unsigned sum_w,
                                          input logic saturate);
      sat_res_t               r;
      logic signed [MaxW-1:0] lim;
      logic signed [MaxW-1:0] hi;
      logic signed [MaxW-1:0] lo;
      logic signed [MaxW-1:0] wrap;
      r.sat    = 1'b0;
      r.result = value;
      if (out_w < sum_w) begin
         lim  = {{(MaxW-1){1'b0}}, 1'b1} << (out_w - 1);
         hi   = lim - 1;
         lo   = -lim;
         // Shift up then arithmetic-shift back: keeps the low out_w bits, sign-extended.
         wrap = value <<< (MaxW - out_w);
         wrap = wrap >>> (MaxW - out_w);
         if (saturate) begin
            if (value > hi) begin
               r.sat    = 1'b1;
               r.result = hi;
            end else if (value < lo) begin
               r.sat    = 1'b1;
               r.result = lo;
            end
         end else begin
            r.sat    = (wrap != value);
            r.result = wrap;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/pipelined_summer_adder_level.sv
// One registered level of the adder tree: pairwise sums of N inputs into N/2
// registers, advancing together with the valid bit only when adv is high.
module adder_level
   import summer_pkg::*;
#(
   parameter int unsigned N = 2,
   parameter int unsigned W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   adv,
   input  logic                   in_valid,
   input  logic [N-1:0][W-1:0]    in_data,
   output logic                   out_valid,
   output logic [N/2-1:0][W-1:0]  out_data
);

   localparam int unsigned M = N / 2;

   logic [M-1:0][W-1:0] sum;

   always_comb begin
      sum = '0;
      for (int i = 0; i < M; i++) begin
         sum[i] = in_data[2*i] + in_data[2*i+1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data  <= '0;
         out_valid <= 1'b0;
      end else if (adv) begin
         out_data  <= sum;
         out_valid <= in_valid;
      end
   end

endmodule

// File: rtl/pipelined_summer.sv
// Pipelined signed adder tree: N_IN operands plus bias, one register per tree
// level, then a saturating (or wrapping) output stage with valid/ready flow.
module pipelined_summer
   import summer_pkg::*;
#(
   parameter int unsigned N_IN     = 32,
   parameter int unsigned IN_W     = 32,
   parameter int unsigned SUM_W    = 64,
   parameter int unsigned OUT_W    = 64,
   parameter bit          SATURATE = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_IN-1:0][IN_W-1:0]   in_data,
   input  logic [IN_W-1:0]             in_bias,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic [OUT_W-1:0]            out_sum,
   output logic                        out_sat,
   output logic                        out_valid,
   input  logic                        out_ready
);

   localparam int unsigned K    = num_levels(N_IN);
   localparam int unsigned P    = 32'd1 << K;
   localparam int unsigned Root = 2 * P - 2;

   if (N_IN < 1) begin : g_err_n_in
      $fatal(1, "pipelined_summer: N_IN must be at least 1");
   end
   if (SUM_W < IN_W + clog2(N_IN + 1)) begin : g_err_sum_w
      $fatal(1, "pipelined_summer: SUM_W too narrow for N_IN operands plus bias");
   end
   if (OUT_W > SUM_W) begin : g_err_out_w
      $fatal(1, "pipelined_summer: OUT_W must not exceed SUM_W");
   end
   if (SUM_W >= MaxW) begin : g_err_max_w
      $fatal(1, "pipelined_summer: SUM_W exceeds the output stage width");
   end

   logic adv;
   assign adv      = !out_valid | out_ready;
   assign in_ready = adv;

   // All tree nodes in one flat array: level k starts at 2P - 2*(P>>k), root last.
   logic [2*P-2:0][SUM_W-1:0] node;
   logic [K:0]                vld;

   assign vld[0] = in_valid;

   for (genvar i = 0; i < P; i++) begin : g_leaf
      if (i < N_IN) begin : g_op
         assign node[i] = {{(SUM_W-IN_W){in_data[i][IN_W-1]}}, in_data[i]};
      end else if (i == N_IN) begin : g_bias
         assign node[i] = {{(SUM_W-IN_W){in_bias[IN_W-1]}}, in_bias};
      end else begin : g_pad
         assign node[i] = '0;
      end
   end

   for (genvar k = 1; k <= K; k++) begin : g_level
      localparam int unsigned InCnt  = P >> (k - 1);
      localparam int unsigned OutCnt = P >> k;
      localparam int unsigned InOff  = 2 * P - 2 * InCnt;
      localparam int unsigned OutOff = 2 * P - 2 * OutCnt;

      adder_level #(
         .N (InCnt),
         .W (SUM_W)
      ) u_level (
         .clk       (clk),
         .rst       (rst),
         .adv       (adv),
         .in_valid  (vld[k-1]),
         .in_data   (node[InOff+InCnt-1:InOff]),
         .out_valid (vld[k]),
         .out_data  (node[OutOff+OutCnt-1:OutOff])
      );
   end

   logic signed [MaxW-1:0] root_ext;
   sat_res_t               sr;

   assign root_ext = {{(MaxW-SUM_W){node[Root][SUM_W-1]}}, node[Root]};

   always_comb begin
      sr = sat_trunc(root_ext, OUT_W, SUM_W, SATURATE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_sat   <= 1'b0;
      end else if (adv) begin
         out_valid <= vld[K];
         out_sum   <= sr.result[OUT_W-1:0];
         out_sat   <= sr.sat;
      end
   end

endmodule
